// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter: core (c_*) and debug system bus (d_*) share one
// single-outstanding bus port (bus_*).
//
// Optional feature macro: BUS_ARBITER__TIMEOUT_EN
//   When defined, a WAIT_ACK watchdog ends a transaction after TimeoutCycles
//   cycles without bus_ack and returns fault=1, rdata=0 to the requester.
//   When undefined, WAIT_ACK waits for bus_ack indefinitely.
//
// Parameters
//   Width          address/data width
//   TimeoutCycles  watchdog limit in WAIT_ACK cycles (1..65535)
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata/c_be   core command, req held until c_done
//   c_rdata/c_done/c_fault           core response (done is a 1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata/d_be   debug command
//   d_rdata/d_done/d_fault           debug response
//   halted                           hart halted, debug takes absolute priority
//   bus_rd/bus_wr                    one-cycle command strobes
//   bus_addr/bus_wdata/bus_be        command fields, held until next grant
//   bus_rdata/bus_ack/bus_fault      bus response, fault qualified by ack
//   owner                            last granted requester (0 core, 1 debug)
module bus_arbiter #(
  parameter int unsigned Width         = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [Width-1:0] c_addr,
  input  logic [Width-1:0] c_wdata,
  input  logic [3:0]       c_be,
  output logic [Width-1:0] c_rdata,
  output logic             c_done,
  output logic             c_fault,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [Width-1:0] d_addr,
  input  logic [Width-1:0] d_wdata,
  input  logic [3:0]       d_be,
  output logic [Width-1:0] d_rdata,
  output logic             d_done,
  output logic             d_fault,
  input  logic             halted,
  output logic             bus_rd,
  output logic             bus_wr,
  output logic [Width-1:0] bus_addr,
  output logic [Width-1:0] bus_wdata,
  output logic [3:0]       bus_be,
  input  logic [Width-1:0] bus_rdata,
  input  logic             bus_ack,
  input  logic             bus_fault,
  output logic             owner
);

  localparam int unsigned BeW  = 4;
  localparam int unsigned CntW = 16;

  // Elaboration-time range check on the watchdog limit.
  if (TimeoutCycles == 0 || TimeoutCycles > 65535) begin : g_cfg_check
    $error("bus_arbiter: TimeoutCycles must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [Width-1:0] addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]   be_q, be_d;
  logic [Width-1:0] c_rdata_q, c_rdata_d;
  logic [Width-1:0] d_rdata_q, d_rdata_d;
  logic             c_done_q, c_done_d;
  logic             d_done_q, d_done_d;
  logic             c_fault_q, c_fault_d;
  logic             d_fault_q, d_fault_d;
`ifdef BUS_ARBITER__TIMEOUT_EN
  logic [CntW-1:0]  cnt_q, cnt_d;
`endif

  logic             win_c;
  logic             resp_c;
  logic [Width-1:0] resp_data_c;
  logic             resp_fault_c;

  // Winner when both request: debug if halted, otherwise the one not granted last.
  assign win_c = (c_req && d_req) ? (halted | ~owner_q) : d_req;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    c_rdata_d    = c_rdata_q;
    d_rdata_d    = d_rdata_q;
    c_done_d     = 1'b0;
    d_done_d     = 1'b0;
    c_fault_d    = 1'b0;
    d_fault_d    = 1'b0;
    resp_c       = 1'b0;
    resp_data_c  = '0;
    resp_fault_c = 1'b0;
`ifdef BUS_ARBITER__TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          state_d = GRANT;
          owner_d = win_c;
          if (win_c) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            be_d    = d_be;
            rd_d    = ~d_we;
            wr_d    = d_we;
          end else begin
            addr_d  = c_addr;
            wdata_d = c_wdata;
            be_d    = c_be;
            rd_d    = ~c_we;
            wr_d    = c_we;
          end
        end
      end
      GRANT: begin
        state_d = WAIT_ACK;
`ifdef BUS_ARBITER__TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_ACK: begin
        if (bus_ack) begin
          resp_c       = 1'b1;
          resp_data_c  = bus_rdata;
          resp_fault_c = bus_fault;
        end
`ifdef BUS_ARBITER__TIMEOUT_EN
        // This cycle is the TimeoutCycles-th without an ack.
        else if (({1'b0, cnt_q} + (CntW+1)'(1)) == (CntW+1)'(TimeoutCycles)) begin
          resp_c       = 1'b1;
          resp_data_c  = '0;
          resp_fault_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Route the response to the requester that owns the transaction.
    if (resp_c) begin
      state_d = RESP;
      if (owner_q) begin
        d_done_d  = 1'b1;
        d_fault_d = resp_fault_c;
        d_rdata_d = resp_data_c;
      end else begin
        c_done_d  = 1'b1;
        c_fault_d = resp_fault_c;
        c_rdata_d = resp_data_c;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      c_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      c_fault_q <= 1'b0;
      d_fault_q <= 1'b0;
`ifdef BUS_ARBITER__TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      c_done_q  <= c_done_d;
      d_done_q  <= d_done_d;
      c_fault_q <= c_fault_d;
      d_fault_q <= d_fault_d;
`ifdef BUS_ARBITER__TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign owner     = owner_q;
  assign bus_rd    = rd_q;
  assign bus_wr    = wr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign c_rdata   = c_rdata_q;
  assign c_done    = c_done_q;
  assign c_fault   = c_fault_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign d_fault   = d_fault_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-timing reference model.
module tb_bus_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         c_req = 1'b0, c_we = 1'b0;
  logic [W-1:0] c_addr = '0, c_wdata = '0;
  logic [3:0]   c_be = '0;
  logic         d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] d_addr = '0, d_wdata = '0;
  logic [3:0]   d_be = '0;
  logic         halted = 1'b0;
  logic [W-1:0] bus_rdata = '0;
  logic         bus_ack = 1'b0, bus_fault = 1'b0;

  logic [W-1:0] c_rdata, d_rdata, bus_addr, bus_wdata;
  logic         c_done, c_fault, d_done, d_fault, bus_rd, bus_wr, owner;
  logic [3:0]   bus_be;

  bus_arbiter #(.Width(W), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_rdata(c_rdata), .c_done(c_done), .c_fault(c_fault),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .d_fault(d_fault),
    .halted(halted),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_fault(bus_fault),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a granted transaction is described by its grant edge m_g;
  // the strobe lives one cycle, acks count only from edge m_g+2, the response
  // is visible for one cycle and a new grant is possible one cycle after that.
  int           m_cyc = 0;
  int           m_g = 0;
  bit           m_busy = 1'b0, m_resp = 1'b0, m_win = 1'b0, m_to = 1'b0, started = 1'b0;
  logic         e_rd = 1'b0, e_wr = 1'b0, e_owner = 1'b0;
  logic         e_cdone = 1'b0, e_ddone = 1'b0, e_cfault = 1'b0, e_dfault = 1'b0;
  logic [W-1:0] e_addr = '0, e_wdata = '0, e_crdata = '0, e_drdata = '0, m_data = '0;
  logic [3:0]   e_be = '0;
  logic         m_fault = 1'b0;

  initial forever begin
    @(posedge clk);
    m_cyc++;
    started = 1'b1;
    e_rd = 1'b0; e_wr = 1'b0;
    e_cdone = 1'b0; e_ddone = 1'b0; e_cfault = 1'b0; e_dfault = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_resp = 1'b0; e_owner = 1'b0;
      e_addr = '0; e_wdata = '0; e_be = '0; e_crdata = '0; e_drdata = '0;
    end else if (m_resp) begin
      m_resp = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (c_req || d_req) begin
        m_win   = (c_req && d_req) ? (halted ? 1'b1 : !e_owner) : d_req;
        e_owner = m_win;
        m_busy  = 1'b1;
        m_g     = m_cyc;
        if (m_win) begin
          e_addr = d_addr; e_wdata = d_wdata; e_be = d_be; e_wr = d_we; e_rd = !d_we;
        end else begin
          e_addr = c_addr; e_wdata = c_wdata; e_be = c_be; e_wr = c_we; e_rd = !c_we;
        end
      end
    end else if (m_cyc - m_g >= 2) begin
      m_to = 1'b0;
`ifdef BUS_ARBITER__TIMEOUT_EN
      m_to = ((m_cyc - m_g - 1) == int'(TO));
`endif
      if (bus_ack || m_to) begin
        m_data  = bus_ack ? bus_rdata : '0;
        m_fault = bus_ack ? bus_fault : 1'b1;
        if (m_win) begin
          e_ddone = 1'b1; e_dfault = m_fault; e_drdata = m_data;
        end else begin
          e_cdone = 1'b1; e_cfault = m_fault; e_crdata = m_data;
        end
        m_resp = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("bus_cmd", {bus_rd, bus_wr, owner, bus_be, bus_addr, bus_wdata},
                     {e_rd, e_wr, e_owner, e_be, e_addr, e_wdata});
      chk("core_rsp", {c_done, c_fault, c_rdata}, {e_cdone, e_cfault, e_crdata});
      chk("dbg_rsp", {d_done, d_fault, d_rdata}, {e_ddone, e_dfault, e_drdata});
    end
  end

  // Stimulus controls.
  int ack_mode  = 0;   // 0 never ack, 1 always ack, 2 random
  bit auto_drop = 1'b1;
  bit rand_en   = 1'b0;

  task automatic step();
    @(negedge clk);
    if (auto_drop) begin
      if (c_req && e_cdone) c_req = 1'b0;
      if (d_req && e_ddone) d_req = 1'b0;
    end
    case (ack_mode)
      0: bus_ack = 1'b0;
      1: bus_ack = 1'b1;
      default: begin
        bus_ack   = ($urandom % 3 == 0);
        bus_rdata = $urandom;
        bus_fault = ($urandom % 4 == 0);
      end
    endcase
    if (rand_en) begin
      if (!c_req && ($urandom % 3 == 0)) begin
        c_req = 1'b1; c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom;
        c_be = 4'($urandom);
      end else if (c_req && !e_cdone && ($urandom % 32 == 0)) begin
        c_req = 1'b0;
      end
      if (!d_req && ($urandom % 3 == 0)) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom);
      end else if (d_req && !e_ddone && ($urandom % 32 == 0)) begin
        d_req = 1'b0;
      end
      if ($urandom % 16 == 0) halted = ~halted;
      rst_n = ($urandom % 400 != 0);
    end
  endtask

  int  n_c, n_d, n, lat;
  bit  got;
  logic [1:0] order;

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("reset_bus", {bus_rd, bus_wr, owner, bus_addr}, '0);
    chk("reset_rsp", {c_done, d_done, c_fault, d_fault, c_rdata, d_rdata}, '0);

    // Core read with ack in the first WAIT_ACK cycle
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100; c_wdata = '0; c_be = 4'hF;
    step();
    chk("rd_strobe", {bus_rd, bus_wr, bus_addr}, {1'b1, 1'b0, 32'h100});
    step();
    chk("rd_strobe_once", bus_rd, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; bus_fault = 1'b0;
    step();
    chk("rd_done", {c_done, c_fault, c_rdata, d_done}, {1'b1, 1'b0, 32'hDEADBEEF, 1'b0});
    step();
    chk("rd_done_pulse", {c_done, c_rdata}, {1'b0, 32'hDEADBEEF});

    // Simultaneous requests after reset: debug first, then core
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ack_mode = 1; bus_rdata = 32'h0000_0A0A;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    step();
    chk("rr_owner_first", {owner, bus_addr}, {1'b1, 32'h20});
    n = 0; order = 2'b00;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step();
      if (c_done || d_done) begin
        if (n < 2) order[1 - n] = d_done;
        n++;
      end
    end
    chk("rr_order", {n[3:0], order, owner}, {4'd2, 2'b10, 1'b0});

    // Halted: debug always wins, core starves
    step(); step();
    halted = 1'b1; auto_drop = 1'b0;
    c_req = 1'b1; d_req = 1'b1;
    n_c = 0; n_d = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (c_done) n_c++;
      if (d_done) n_d++;
    end
    chk("halt_core_starved", n_c, 0);
    chk("halt_dbg_served", {(n_d >= 8), owner}, {1'b1, 1'b1});
    c_req = 1'b0; d_req = 1'b0; halted = 1'b0; auto_drop = 1'b1;
    repeat (5) step();

    // Debug write answered with a bus fault
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'hF;
    bus_fault = 1'b1;
    step();
    chk("wr_strobe", {bus_rd, bus_wr, bus_addr, bus_wdata, bus_be},
                     {1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF});
    step();
    chk("wr_strobe_once", bus_wr, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (d_done) begin
        got = 1'b1;
        chk("wr_fault", {d_fault, c_done}, {1'b1, 1'b0});
      end
    end
    if (!got) chk("wr_done_timeout", 1'b0, 1'b1);
    bus_fault = 1'b0;
    repeat (2) step();

    // No ack at all
    ack_mode = 0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h300;
`ifdef BUS_ARBITER__TIMEOUT_EN
    got = 1'b0; lat = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      lat++;
      if (c_done) begin
        got = 1'b1;
        chk("to_resp", {c_fault, c_rdata}, {1'b1, 32'h0});
      end
    end
    chk("to_latency", {got, lat[7:0]}, {1'b1, 8'd6});
    repeat (2) step();
`else
    n_c = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (c_done) n_c++;
    end
    chk("no_to_waits", {n_c, bus_rd}, '0);
    rst_n = 1'b0; c_req = 1'b0;
    step();
    rst_n = 1'b1;
`endif

    // Reset in WAIT_ACK, then a late ack
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h400;
    repeat (3) step();
    rst_n = 1'b0; c_req = 1'b0;
    step();
    rst_n = 1'b1; ack_mode = 1; bus_rdata = 32'hCAFE0001;
    chk("rst_bus", {bus_rd, bus_wr, owner, bus_be, bus_addr, bus_wdata}, '0);
    chk("rst_rsp", {c_done, c_fault, d_done, d_fault, c_rdata, d_rdata}, '0);
    n_c = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (c_done || d_done) n_c++;
    end
    chk("rst_no_done", n_c, 0);
    c_req = 1'b1; c_addr = 32'h404;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (c_done) begin
        got = 1'b1;
        chk("rst_recover", {c_fault, c_rdata}, {1'b0, 32'hCAFE0001});
      end
    end
    if (!got) chk("rst_recover_timeout", 1'b0, 1'b1);
    repeat (2) step();

    // Randomized traffic
    ack_mode = 2; rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0; rst_n = 1'b1; ack_mode = 0;
    c_req = 1'b0; d_req = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
